// File: rtl/cordic_pkg.sv
// Shared definitions for the enhanced-CORDIC micro-rotation front end.
// Angles are signed Q2.13 radians: 1 LSB = 2^-13 rad, range [-4, +4).
package cordic_pkg;

  localparam int ANGLE_W  = 16;
  localparam int ANG5_LSB = 256;  // 2^-5 rad, shift-5 micro-rotation
  localparam int ANG6_LSB = 128;  // 2^-6 rad, shift-6 micro-rotation
  localparam int TH6_LSB  = 64;   // ANG6/2: below this a step would overshoot

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Control triple consumed by the iteration stage.
  typedef struct packed {
    logic c2;  // 1 = negative rotation
    logic c1;  // 0 = shift 5, 1 = shift 6
    logic c0;  // 1 = rotate, 0 = pass X,Y through
  } ctrl_t;

endpackage

// File: rtl/iter_ctrl_decide.sv
// Greedy micro-rotation decision for one residual.
//   r     : residual, W+1 bits signed
//   step  : |r| >= TH6, a micro-rotation is worthwhile
//   c2    : rotation direction (sign of r)
//   c1    : 0 = ANG5 step, 1 = ANG6 step
//   r_nxt : residual after the step (equals r when no step)
module iter_ctrl_decide #(
  parameter int W    = 16,
  parameter int ANG5 = 256,
  parameter int ANG6 = 128,
  parameter int TH6  = 64
) (
  input  logic signed [W:0] r,
  output logic              step,
  output logic              c2,
  output logic              c1,
  output logic signed [W:0] r_nxt
);

  localparam int WP = W + 1;
  localparam logic [W:0] A5 = WP'(ANG5);
  localparam logic [W:0] A6 = WP'(ANG6);
  localparam logic [W:0] T6 = WP'(TH6);

  logic        [W:0] mag;
  logic signed [W:0] a;

  // r is sign-extended from a W-bit angle, so -r cannot overflow W+1 bits.
  assign mag = r[W] ? -r : r;
  assign c2  = r[W];

  always_comb begin
    step = 1'b0;
    c1   = 1'b0;
    a    = '0;
    if (mag >= A5) begin
      step = 1'b1;
      a    = A5;
    end else if (mag >= T6) begin
      step = 1'b1;
      c1   = 1'b1;
      a    = A6;
    end
    // Always rotate toward zero.
    r_nxt = c2 ? (r + a) : (r - a);
  end

endmodule

// File: rtl/iter_ctrl_seq.sv
// Upstream control sequencer for the enhanced-CORDIC micro-rotation stage.
// Decomposes a target angle into ANG5/ANG6 micro-rotations and issues one
// control triple per step over a valid/ready handshake.
//   start/z_in              : begin a new angle (only honoured in IDLE)
//   step_valid/step_ready   : triple handshake; c2/c1/c0 and step_last ride with it
//   busy                    : sequence in progress (RUN or FIN)
//   done                    : one-cycle pulse, z_res/n_steps/ovf valid from then on
module iter_ctrl_seq
  import cordic_pkg::*;
#(
  parameter int W         = ANGLE_W,
  parameter int MAX_STEPS = 16,
  parameter int ANG5      = ANG5_LSB,
  parameter int ANG6      = ANG6_LSB,
  parameter int TH6       = TH6_LSB,
  localparam int CW       = $clog2(MAX_STEPS + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] z_in,
  output logic         busy,
  output logic         step_valid,
  input  logic         step_ready,
  output logic         c2,
  output logic         c1,
  output logic         c0,
  output logic         step_last,
  output logic         done,
  output logic [W-1:0] z_res,
  output logic [CW-1:0] n_steps,
  output logic         ovf
);

  localparam logic [CW-1:0] MAXC = CW'(MAX_STEPS);

  state_t            state;
  logic signed [W:0] r;
  logic [CW-1:0]     cnt;

  logic              step_now, c2_now, c1_now;
  logic signed [W:0] r_nxt;
  logic              step_nxt;
  logic              unused_c2_nxt, unused_c1_nxt;
  logic signed [W:0] unused_r_nxt2;
  ctrl_t             trip;

  iter_ctrl_decide #(.W(W), .ANG5(ANG5), .ANG6(ANG6), .TH6(TH6)) u_dec_now (
    .r(r), .step(step_now), .c2(c2_now), .c1(c1_now), .r_nxt(r_nxt)
  );

  // Lookahead on the post-step residual decides whether this triple is the last.
  iter_ctrl_decide #(.W(W), .ANG5(ANG5), .ANG6(ANG6), .TH6(TH6)) u_dec_nxt (
    .r(r_nxt), .step(step_nxt), .c2(unused_c2_nxt), .c1(unused_c1_nxt),
    .r_nxt(unused_r_nxt2)
  );

  // Triple depends only on registered r/cnt/state, so it holds while stalled.
  assign step_valid = (state == RUN) && step_now && (cnt < MAXC);
  assign trip       = '{c2: c2_now & step_valid, c1: c1_now & step_valid, c0: step_valid};
  assign c2         = trip.c2;
  assign c1         = trip.c1;
  assign c0         = trip.c0;
  assign step_last  = step_valid && (!step_nxt || (cnt == MAXC - CW'(1)));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      r       <= '0;
      cnt     <= '0;
      z_res   <= '0;
      n_steps <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r       <= {z_in[W-1], z_in};
            cnt     <= '0;
            z_res   <= '0;
            n_steps <= '0;
            ovf     <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (step_valid && step_ready) begin
            r   <= r_nxt;
            cnt <= cnt + CW'(1);
          end else if (!step_valid) begin
            // Results are latched on entry to FIN so they are valid alongside done.
            // step_now is exactly |r| >= TH6, i.e. work left undone.
            state   <= FIN;
            done    <= 1'b1;
            z_res   <= r[W-1:0];
            n_steps <= cnt;
            ovf     <= step_now;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_ctrl_seq.sv
module tb_iter_ctrl_seq;

  localparam int W    = 16;
  localparam int MAXS = 16;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          rst, start, step_ready;
  logic [W-1:0]  z_in;
  logic          busy, step_valid, c2, c1, c0, step_last, done, ovf;
  logic [W-1:0]  z_res;
  logic [CW-1:0] n_steps;

  iter_ctrl_seq dut (
    .clk(clk), .rst(rst), .start(start), .z_in(z_in), .busy(busy),
    .step_valid(step_valid), .step_ready(step_ready), .c2(c2), .c1(c1), .c0(c0),
    .step_last(step_last), .done(done), .z_res(z_res), .n_steps(n_steps), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: greedy decomposition straight from the rules, in plain integers.
  int m_c2[$];
  int m_c1[$];
  int m_res, m_n, m_ovf;

  task automatic run_model(input logic [W-1:0] z);
    int res, a;
    m_c2.delete();
    m_c1.delete();
    res = int'($signed(z));
    while (m_c2.size() < MAXS && (res >= 64 || res <= -64)) begin
      a = (res >= 256 || res <= -256) ? 256 : 128;
      m_c2.push_back(res < 0 ? 1 : 0);
      m_c1.push_back(a == 128 ? 1 : 0);
      res = (res < 0) ? res + a : res - a;
    end
    m_res = res & 32'hFFFF;
    m_n   = m_c2.size();
    m_ovf = (res >= 64 || res <= -64) ? 1 : 0;
  endtask

  // stall >= 0: ready held low that many cycles before each acceptance.
  // stall <  0: ready random every cycle. exp_res < 0: expect the model's result.
  task automatic run_angle(input string tag, input logic [W-1:0] z, input int stall,
                           input bit poke, input int exp_res, input int exp_n,
                           input int exp_ovf);
    int idx, held, cyc, last_cyc, done_cyc, er, en, eo;
    bit hs, poked;
    run_model(z);
    if (exp_res < 0) begin er = m_res; en = m_n; eo = m_ovf; end
    else begin er = exp_res; en = exp_n; eo = exp_ovf; end
    @(posedge clk); #1;
    z_in = z; start = 1'b1; held = 0;
    step_ready = (stall < 0) ? 1'($urandom_range(0, 1)) : (stall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0; last_cyc = 0; done_cyc = -1; poked = 0;
    for (int k = 0; k < 400 && done_cyc < 0; k++) begin
      @(negedge clk);
      cyc++;
      hs = 0;
      if (cyc == 1) begin
        chk({tag, "_first_valid"}, step_valid, (m_c2.size() > 0));
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_cleared"}, {ovf, n_steps, z_res}, 0);
      end
      if (done) begin
        done_cyc = cyc;
        chk({tag, "_busy_at_done"}, busy, 1);
      end else if (step_valid) begin
        if (idx >= m_c2.size()) chk({tag, "_extra_triple"}, idx, m_c2.size());
        else begin
          chk({tag, "_c2"}, c2, m_c2[idx]);
          chk({tag, "_c1"}, c1, m_c1[idx]);
          chk({tag, "_c0"}, c0, 1);
          chk({tag, "_last"}, step_last, (idx == m_c2.size() - 1));
        end
        if (step_ready) begin hs = 1; last_cyc = cyc; idx++; end
      end else begin
        chk({tag, "_idle_triple"}, {c2, c1, c0, step_last}, 0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (poke && !poked && idx == 1 && done_cyc < 0) begin
        start = 1'b1; z_in = ~z; poked = 1;
      end
      if (stall < 0) step_ready = 1'($urandom_range(0, 1));
      else begin
        held = hs ? 0 : held + 1;
        step_ready = (held >= stall);
      end
    end
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL %s_timeout: no done within 400 cycles", tag);
      return;
    end
    chk({tag, "_done_lat"}, done_cyc, (idx > 0) ? last_cyc + 2 : 2);
    chk({tag, "_n_triples"}, idx, m_c2.size());
    chk({tag, "_z_res"}, z_res, er);
    chk({tag, "_n_steps"}, n_steps, en);
    chk({tag, "_ovf"}, ovf, eo);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {done, busy}, 0);
    chk({tag, "_z_res_held"}, z_res, er);
  endtask

  typedef struct {
    string      tag;
    logic [W-1:0] z;
    int         stall;
    bit         poke;
    int         res;
    int         n;
    int         ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; start = 1'b0; step_ready = 1'b0; z_in = '0;
    #23;
    chk("reset_outputs",
        {busy, step_valid, c2, c1, c0, step_last, done, ovf, n_steps, z_res}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    vecs.push_back('{"p640",     16'd640,   0, 0, 0,     3,  0});
    vecs.push_back('{"m200",     16'hFF38,  0, 0, 56,    2,  0});
    vecs.push_back('{"p30",      16'd30,    0, 0, 30,    0,  0});
    vecs.push_back('{"p8000",    16'd8000,  0, 0, 3904,  16, 1});
    vecs.push_back('{"p640stl",  16'd640,   3, 1, 0,     3,  0});
    vecs.push_back('{"p63",      16'd63,    0, 0, 63,    0,  0});
    vecs.push_back('{"p64",      16'd64,    0, 0, 64,    16, 1});
    vecs.push_back('{"p256",     16'd256,   0, 0, 0,     1,  0});
    vecs.push_back('{"mmin",     16'h8000,  0, 0, 36864, 16, 1});
    foreach (vecs[i])
      run_angle(vecs[i].tag, vecs[i].z, vecs[i].stall, vecs[i].poke,
                vecs[i].res, vecs[i].n, vecs[i].ovf);

    // Asynchronous reset after the first handshake of +640.
    @(posedge clk); #1;
    z_in = 16'd640; start = 1'b1; step_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_pre_valid", step_valid, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs",
        {busy, step_valid, c2, c1, c0, step_last, done, ovf, n_steps, z_res}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_angle("m200_after_rst", 16'hFF38, 0, 0, 56, 2, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] z;
      int t;
      if (i % 2 == 0) z = W'($urandom);
      else begin
        t = int'($urandom_range(0, 1200)) - 600;
        z = t[W-1:0];
      end
      run_angle("rand", z, -1, (i % 5 == 0), -1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_ctrl_seq.md
Name: iter_ctrl_seq

Overview:
- Upstream control sequencer for the enhanced-CORDIC micro-rotation stage.
- Takes a signed target angle and greedily decomposes it into micro-rotations of about 2^-5 or 2^-6 rad.
- Emits one control triple (c2 direction, c1 shift select, c0 enable) per accepted step to the iteration datapath over a valid/ready handshake.
- Reports the residual angle, step count and saturation on completion.

Parameters:
- W, 16, angle width; signed, radians, Q2.13 (1 LSB = 2^-13 rad).
- MAX_STEPS, 16, maximum micro-rotations per angle.
- ANG5, 256, angle of a shift-5 step in LSB (2^-5 rad).
- ANG6, 128, angle of a shift-6 step in LSB (2^-6 rad).
- TH6, 64, minimum |residual| that still triggers a step (ANG6/2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse; sampled only in IDLE.
- z_in  input  W  signed target angle; captured on accepted start.
- busy  output  1  high in RUN and FIN.
- step_valid  output  1  control triple valid.
- step_ready  input  1  iteration stage accepts the triple.
- c2  output  1  1 = negative rotation; residual was negative.
- c1  output  1  0 = shift 5, 1 = shift 6.
- c0  output  1  1 when step_valid, else 0 (downstream passes X,Y through).
- step_last  output  1  qualifies the final triple of the sequence.
- done  output  1  one-cycle completion pulse.
- z_res  output  W  final residual angle, held until next start.
- n_steps  output  $clog2(MAX_STEPS+1)  steps issued, held until next start.
- ovf  output  1  MAX_STEPS reached with |residual| >= TH6; held until next start.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0: busy, step_valid, c2, c1, c0, step_last, done, z_res, n_steps, ovf. Internal residual and counter cleared.
- Internal residual r: W+1 bits, signed, sign-extended from z_in. No wrap is possible.
- Decision, combinational from r:
  - |r| >= ANG5 -> c1=0, a=ANG5.
  - else |r| >= TH6 -> c1=1, a=ANG6.
  - else -> no step.
  - c2 = r[W] (sign bit).
  - Next residual r' = r - a when c2=0, r + a when c2=1.
- IDLE:
  - start=1 -> capture r=z_in, cnt=0, clear z_res/n_steps/ovf, go RUN next cycle.
  - start=0 -> remain.
- RUN:
  - step_valid = decision gives a step AND cnt < MAX_STEPS. Triple is registered-stable while step_valid && !step_ready.
  - On step_valid && step_ready: r <= r', cnt <= cnt+1.
  - step_last = step_valid && (decision on r' gives no step OR cnt+1 == MAX_STEPS).
  - Leave RUN for FIN when no step remains or cnt == MAX_STEPS: the cycle after the last handshake, or the first RUN cycle for a sub-threshold angle.
- FIN: one cycle.
  - done=1. z_res <= r[W-1:0], n_steps <= cnt, ovf <= (|r| >= TH6).
  - Go IDLE next cycle.
- Latency:
  - First triple appears 1 cycle after start.
  - With step_ready tied high: one step per cycle; done arrives 2 cycles after the last triple.
  - Zero-step angle: done 2 cycles after start.
- start while busy: ignored, no effect.
- step_ready while step_valid=0: ignored.
- Reset mid-operation: immediate abort to IDLE with outputs zeroed. Any in-flight triple is dropped; the downstream stage is expected to be reset together.

Decomposition:
- Shared package cordic_pkg holds:
  - state enum {IDLE, RUN, FIN};
  - constants ANG5, ANG6, TH6, angle width W, angle Q-format comment;
  - control-triple struct {c2, c1, c0} for reuse by the iteration stage.
- One natural sub-module: iter_ctrl_decide. Combinational: r -> {step, c2, c1, r'}. Reused by the step_last lookahead, which instantiates it twice.

Test Plan:
- z_in=+640, step_ready=1 -> triples (c2,c1)=(0,0),(0,0),(0,1); step_last on the 3rd; done; z_res=0, n_steps=3, ovf=0.
- z_in=-200 -> (1,1) giving r=-72, then (1,1) giving r=+56; step_last on the 2nd; z_res=56, n_steps=2.
- z_in=30 -> no step_valid; done 2 cycles after start; z_res=30, n_steps=0.
- z_in=8000 -> 16 triples (0,0); step_last on the 16th; z_res=3904, n_steps=16, ovf=1.
- z_in=+640 with step_ready low 3 cycles on each step -> c2/c1/step_valid stable while stalled; same final result as the first test. start pulsed mid-RUN -> ignored.
- rst asserted after the 1st handshake of z_in=+640 -> all outputs 0 asynchronously; a new start with z_in=-200 then completes as in the second test.
